// File: rtl/mem_pkg.sv
// Shared types for the MEM-stage store buffer.
// Entry layout, match classes and default bus widths.
package mem_pkg;

    localparam int MEM_ADDR_WIDTH = 20;
    localparam int MEM_DATA_WIDTH = 32;
    localparam int MEM_READ_WIDTH = 20;

    typedef struct packed {
        logic [MEM_ADDR_WIDTH-1:0] addr;
        logic [MEM_DATA_WIDTH-1:0] data;
        logic                      is_byte;
    } sb_entry_t;

    typedef enum logic [1:0] {
        NO_MATCH,
        FWD,
        CONFLICT
    } sb_match_e;

endpackage

// File: rtl/sb_addr_match.sv
// Youngest-match search of a load address over the live buffer entries.
// Ports: addrs/byte_en entry fields, head/count live window,
//        req_addr/req_byte load, kind match class, idx youngest hit.
// Macro MEM_STORE_BUFFER_STORE_FWD_EN enables word-to-word FWD class.
module sb_addr_match
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = PW + 1
) (
    input  logic [MEM_ADDR_WIDTH-1:0] addrs   [DEPTH],
    input  logic                      byte_en [DEPTH],
    input  logic [PW-1:0]             head,
    input  logic [CW-1:0]             count,
    input  logic [MEM_ADDR_WIDTH-1:0] req_addr,
    input  logic                      req_byte,
    output sb_match_e                 kind,
    output logic [PW-1:0]             idx
);

    logic          hit;
    logic          fwd_ok;
    logic [PW-1:0] pos;

    // Walk oldest to youngest so the last hit is the youngest.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        pos = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pos = head + PW'(i);
            if (i < int'(count) &&
                addrs[pos][MEM_ADDR_WIDTH-1:2] ==
                req_addr[MEM_ADDR_WIDTH-1:2]) begin
                hit = 1'b1;
                idx = pos;
            end
        end
    end

    assign fwd_ok = !byte_en[idx] && !req_byte &&
                    (addrs[idx] == req_addr);

    always_comb begin
        kind = NO_MATCH;
        if (hit) begin
            kind = CONFLICT;
`ifdef MEM_STORE_BUFFER_STORE_FWD_EN
            if (fwd_ok) begin
                kind = FWD;
            end
`endif
        end
    end

`ifndef MEM_STORE_BUFFER_STORE_FWD_EN
    logic unused_fwd_ok;
    assign unused_fwd_ok = fwd_ok;
`endif

endmodule

// File: rtl/mem_store_buffer.sv
// MEM-stage store buffer: queues stores, drains them in idle port slots,
// forwards/stalls/reads for loads. Ports: req_* pipeline request with
// req_ready, drain_req flush, empty, ld_valid/ld_data registered load
// result, mem_* single-port data memory. Reset rst is async active-low.
// Macro MEM_STORE_BUFFER_STORE_FWD_EN enables word store-to-load forwarding.
module mem_store_buffer
    import mem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH    = MEM_DATA_WIDTH,
    parameter int READ_WIDTH    = MEM_READ_WIDTH,
    parameter int DEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_load,
    input  logic                     req_store,
    input  logic                     req_byte,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    input  logic                     drain_req,
    output logic                     empty,
    output logic                     ld_valid,
    output logic [READ_WIDTH-1:0]    ld_data,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic                     mem_we,
    output logic                     mem_re,
    output logic                     mem_be,
    input  logic [READ_WIDTH-1:0]    mem_rdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t                ent [DEPTH];
    logic [ADDRESS_WIDTH-1:0] e_addr [DEPTH];
    logic                     e_byte [DEPTH];
    logic [PW-1:0]            head;
    logic [PW-1:0]            tail;
    logic [CW-1:0]            count;
    sb_entry_t                hd;
    sb_match_e                m_kind;
    logic [PW-1:0]            m_idx;

    logic is_ld;
    logic is_st;
    logic stall;
    logic full;
    logic ld_mem;
    logic ld_fwd;
    logic push;
    logic pop;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            e_addr[i] = ent[i].addr;
            e_byte[i] = ent[i].is_byte;
        end
    end

    sb_addr_match #(
        .DEPTH (DEPTH)
    ) u_match (
        .addrs    (e_addr),
        .byte_en  (e_byte),
        .head     (head),
        .count    (count),
        .req_addr (req_addr),
        .req_byte (req_byte),
        .kind     (m_kind),
        .idx      (m_idx)
    );

    assign hd    = ent[head];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // Load+store together is illegal: accepted but does nothing.
    assign is_ld = req_valid & req_load & ~req_store;
    assign is_st = req_valid & req_store & ~req_load;

    assign stall     = is_ld & (m_kind == CONFLICT);
    assign req_ready = ~drain_req & ~stall;
    assign ld_mem    = is_ld & req_ready & (m_kind == NO_MATCH);
    assign ld_fwd    = is_ld & req_ready & (m_kind == FWD);
    assign push      = is_st & ~drain_req;

    // A load reading memory owns the port; otherwise drain opportunistically.
    assign pop = ~empty & ~ld_mem &
                 (~req_valid | stall | (full & push) | drain_req);

    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_be    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ld_mem) begin
            mem_re   = 1'b1;
            mem_addr = req_addr;
            mem_be   = req_byte;
        end else if (pop) begin
            mem_we    = 1'b1;
            mem_addr  = hd.addr;
            mem_wdata = hd.data;
            mem_be    = hd.is_byte;
        end
    end

    // Entry storage is not reset; count alone decides what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            ent[tail] <= {req_addr, req_wdata, req_byte};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            ld_valid <= 1'b0;
            ld_data  <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            count    <= count + CW'(push) - CW'(pop);
            ld_valid <= ld_mem | ld_fwd;
            if (ld_mem) begin
                ld_data <= mem_rdata;
            end else if (ld_fwd) begin
                ld_data <= ent[m_idx].data[READ_WIDTH-1:0];
            end
        end
    end

endmodule

// File: doc/mem_store_buffer.md
Name: mem_store_buffer

Overview:
- MEM-stage store buffer between the EX/MEM pipeline register and the single-port data memory.
- Stores are queued and written to memory lazily, only in free memory-port slots. This gives loads priority on the port.
- Loads check pending stores for the same word and either forward the data, stall, or read memory directly.
- Load results are registered one cycle after acceptance and feed the MEM/WB register.

Parameters:
- ADDRESS_WIDTH, 20, byte address width.
- DATA_WIDTH, 32, store data width driven to memory.
- READ_WIDTH, 20, load data width returned by memory.
- DEPTH, 4, buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle.
- req_load  in  1  load request.
- req_store  in  1  store request.
- req_byte  in  1  byte access (lbp/sbp); 0 = word access (lwp/swp).
- req_addr  in  ADDRESS_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data.
- drain_req  in  1  flush the buffer (before halt/IO).
- empty  out  1  buffer holds no entries.
- ld_valid  out  1  load result valid; single-cycle pulse.
- ld_data  out  READ_WIDTH  load result.
- mem_addr  out  ADDRESS_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_we  out  1  memory write enable.
- mem_re  out  1  memory read enable.
- mem_be  out  1  memory byte enable.
- mem_rdata  in  READ_WIDTH  combinational memory read data.

Behaviour:
- Reset: head, tail and count cleared to 0. Entries are discarded and never written to memory.
- Reset values of outputs: ld_valid=0, ld_data=0, empty=1, req_ready=1, mem_we=0, mem_re=0, mem_be=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation drops all pending stores.
- Entry fields: addr, data, byte. FIFO order, circular pointers wrapping at DEPTH.
- Match rule: an entry matches when entry.addr[ADDRESS_WIDTH-1:2] equals req_addr[ADDRESS_WIDTH-1:2]. The youngest matching entry wins.
- Store acceptance: accepted whenever drain_req=0. The store is pushed at the clock edge.
- Store when count==DEPTH: the head entry is drained that same cycle (pop+push), so count stays DEPTH.
- Load, no match: accepted. Same cycle mem_re=1, mem_addr=req_addr, mem_be=req_byte. mem_rdata is captured into ld_data at the edge, and ld_valid=1 in the next cycle.
- Load, forwarded: applies only when the youngest match is a word store, the load is a word load, and the full address is equal. The load is accepted with mem_re=0, ld_data=entry.data[READ_WIDTH-1:0], and ld_valid=1 next cycle.
- Load, any other match: stall with req_ready=0. Matching entries drain; the load is accepted once no entry matches.
- Drain trigger: the head entry is issued with mem_we=1, mem_addr, mem_wdata and mem_be=entry.byte, then popped. This happens when count>0, no load is using the port this cycle, and any of these holds:
  - req_valid=0,
  - the request is stalled,
  - count==DEPTH with a store arriving,
  - drain_req=1.
- Port arbitration: an accepted load always owns the port. mem_we and mem_re are never both 1.
- drain_req=1: req_ready=0 and one drain per cycle until empty=1.
- req_load and req_store both set: illegal. The request is accepted and ignored, with no memory access.
- Out-of-range addresses are buffered and passed through unchanged; the memory itself drops them.

Optional Feature:
- Macro: MEM_STORE_BUFFER_STORE_FWD_EN.
- Defined: word-to-word forwarding as described under Behaviour.
- Undefined: any match stalls until drained, and the load then reads memory.

Decomposition:
- mem_pkg holds:
  - sb_entry_t struct {addr, data, byte},
  - MEM_ADDR_WIDTH=20, MEM_DATA_WIDTH=32, MEM_READ_WIDTH=20,
  - sb_match_e enum {NO_MATCH, FWD, CONFLICT}.
- Sub-module sb_addr_match: combinational youngest-match search over the valid entries. It outputs sb_match_e and the matching entry index.

Test Plan:
- Word store 0x00010/0x0ABCDE, then idle -> next cycle mem_we=1, mem_be=0, mem_addr=0x00010, mem_wdata=0x0ABCDE; following cycle empty=1.
- Word stores to 0x0, 0x4, 0x8, 0xC back-to-back, then store 0x10 -> on the 5th cycle mem_we=1 to 0x0, req_ready=1, count stays 4; idle cycles then drain 0x4, 0x8, 0xC, 0x10 in order.
- Word store 0x20=0x11111, then word load 0x20 -> mem_re=0, next cycle ld_valid=1, ld_data=0x11111. With the macro undefined: one stall cycle, drain, then mem_re=1.
- Byte store 0x21=0xAA, then byte load 0x20 -> req_ready=0 for one cycle with mem_we=1 to 0x21; load accepted next cycle with mem_re=1, mem_be=1.
- Load 0x40 with no match, mem_rdata=0x00055 -> mem_re=1 same cycle, ld_valid=1 and ld_data=0x00055 next cycle.
- Two stores buffered, rst pulsed low -> empty=1 immediately; after release no mem_we ever asserted for those stores.
